// File: rtl/ex_mem_lsu.sv
// Load/store unit: drives DMEM/IO in the EX cycle; aligns and extends read data one cycle later.
// Latency: stores commit at the EX edge, loads return 1 cycle later; stall freezes the EX/MEM register and gates enables.
module ex_mem_lsu #(
  parameter int         DMEM_AW   = 12,
  parameter logic [3:0] IO_NIBBLE = 4'h8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  input  logic               stall,
  input  logic               flush,
  output logic               dmem_en,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  input  logic [31:0]        dmem_dout,
  output logic               io_en,
  output logic               io_we,
  output logic [31:0]        io_addr,
  output logic [31:0]        io_wdata,
  input  logic [31:0]        io_rdata,
  output logic [31:0]        load_data,
  output logic               load_valid,
  output logic               misaligned
);

  logic       is_mem;
  logic       legal_funct3;
  logic       aligned;
  logic       io_sel;
  logic       go;
  logic [3:0] byte_we;

  logic       r_valid;
  logic       r_load;
  logic       r_mis;
  logic [2:0] r_funct3;
  logic [1:0] r_off;
  logic       r_io;

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_mem = is_load | is_store;
  assign io_sel = (addr[31:28] == IO_NIBBLE);

  always_comb begin
    legal_funct3 = 1'b0;
    if (is_load) begin
      case (funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_funct3 = 1'b1;
        default:                      legal_funct3 = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'd0, 3'd1, 3'd2: legal_funct3 = 1'b1;
        default:          legal_funct3 = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // rst is folded in so a valid presented during reset never touches memory.
  assign go = valid & is_mem & ~rst & ~stall & ~flush & aligned & legal_funct3;

  assign dmem_en   = go & ~io_sel;
  assign io_en     = go & io_sel;
  assign io_we     = io_en & is_store;
  assign dmem_addr = addr[DMEM_AW+1:2];
  assign io_addr   = addr;
  assign io_wdata  = store_data;

  always_comb begin
    case (funct3[1:0])
      2'd0:    byte_we = 4'b0001 << addr[1:0];
      2'd1:    byte_we = 4'b0011 << addr[1:0];
      default: byte_we = 4'b1111;
    endcase
  end

  assign dmem_we = (dmem_en & is_store) ? byte_we : 4'b0000;

  always_comb begin
    case (funct3[1:0])
      2'd0:    dmem_din = {4{store_data[7:0]}};
      2'd1:    dmem_din = {2{store_data[15:0]}};
      default: dmem_din = store_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_load   <= 1'b0;
      r_mis    <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_io     <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_load  <= 1'b0;
      r_mis   <= 1'b0;
    end else if (!stall) begin
      r_valid  <= valid;
      r_load   <= is_load & go;
      r_funct3 <= funct3;
      r_off    <= addr[1:0];
      r_io     <= io_sel;
      r_mis    <= valid & is_mem & ~aligned & legal_funct3;
    end
  end

  // Memory outputs hold while enables are low, so the MEM result is stable across stalls.
  assign word     = r_io ? io_rdata : dmem_dout;
  assign byte_sel = word[{r_off, 3'b000} +: 8];
  assign half_sel = word[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'd0;
    if (r_load) begin
      case (r_funct3)
        3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
        3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
        3'd4:    load_data = {24'd0, byte_sel};
        3'd5:    load_data = {16'd0, half_sel};
        default: load_data = word;
      endcase
    end
  end

  assign load_valid = r_valid & r_load;
  assign misaligned = r_valid & r_mis;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Randomized bench for ex_mem_lsu against a byte-addressed golden memory with a response scoreboard.
module tb_ex_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_din, dmem_dout;
  logic        io_en, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [31:0] load_data;
  logic        load_valid, misaligned;

  ex_mem_lsu #(.DMEM_AW(12), .IO_NIBBLE(4'h8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .flush(flush),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .io_en(io_en), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .load_data(load_data),
    .load_valid(load_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Device models: synchronous SRAM with byte lanes, IO block with whole-word writes.
  logic [31:0] dmem [0:4095];
  logic [31:0] iomem [0:63];
  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 64; i++) iomem[i] = 32'd0;
    dmem_dout = 32'd0;
    io_rdata  = 32'd0;
  end
  always @(posedge clk) begin
    if (dmem_en) begin
      dmem_dout <= dmem[dmem_addr];
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) dmem[dmem_addr][8*i +: 8] <= dmem_din[8*i +: 8];
    end
    if (io_en) begin
      io_rdata <= iomem[io_addr[7:2]];
      if (io_we) iomem[io_addr[7:2]] <= io_wdata;
    end
  end

  typedef struct {
    logic [31:0] data;
    bit          lv;
    bit          mis;
    int          cyc;
  } resp_t;

  resp_t       q[$];
  resp_t       held;
  logic [7:0]  gmem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          upd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gbyte(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : 8'h00;
  endfunction

  // Golden load: gather little-endian bytes, then extend by the RISC-V width/sign rule.
  function automatic logic [31:0] gload(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int nb;
    nb = 1 << f3[1:0];
    v = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(gbyte(a + i)) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk) begin
    upd = rst | flush | ~stall;
    cyc++;
  end

  always @(negedge clk) begin
    if (upd) begin
      if (q.size() > 0 && q[0].cyc < cyc) held = q.pop_front();
      else held = '{data: 32'd0, lv: 1'b0, mis: 1'b0, cyc: 0};
    end
    chk("load_valid", {31'd0, load_valid}, {31'd0, held.lv});
    chk("misaligned", {31'd0, misaligned}, {31'd0, held.mis});
    chk("load_data", load_data, held.data);
  end

  task automatic step(input bit v, ld, st, input logic [2:0] f3,
                      input logic [31:0] a, d, input bit stl, fl, rs);
    bit legal, al, go, io;
    int nb;
    logic [3:0] we;
    @(posedge clk); #1;
    valid = v; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = d; stall = stl; flush = fl; rst = rs;
    #3;
    nb    = 1 << f3[1:0];
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (st && f3 inside {3'd0, 3'd1, 3'd2});
    al    = (f3[1:0] != 2'd3) && ((a % nb) == 0);
    go    = v && (ld || st) && !stl && !fl && !rs && legal && al;
    io    = (a[31:28] == 4'h8);
    we    = (go && !io && st) ? 4'(((1 << nb) - 1) << (a % 4)) : 4'd0;
    chk("dmem_en", {31'd0, dmem_en}, {31'd0, go && !io});
    chk("io_en", {31'd0, io_en}, {31'd0, go && io});
    chk("io_we", {31'd0, io_we}, {31'd0, go && io && st});
    chk("dmem_we", {28'd0, dmem_we}, {28'd0, we});
    if (go && !io) chk("dmem_addr", {20'd0, dmem_addr}, (a / 4) % 4096);
    if (we != 4'd0)
      chk("dmem_din", dmem_din, (nb == 1) ? {24'd0, d[7:0]} * 32'h0101_0101 :
                                (nb == 2) ? {16'd0, d[15:0]} * 32'h0001_0001 : d);
    if (go && io) chk("io_addr", io_addr, a);
    if (go && io && st) chk("io_wdata", io_wdata, d);
    if (go && st) for (int i = 0; i < nb; i++) gmem[a + i] = d[8*i +: 8];
    if (go && ld) q.push_back('{data: gload(f3, a), lv: 1'b1, mis: 1'b0, cyc: cyc});
    if (v && (ld || st) && !stl && !fl && !rs && legal && !al)
      q.push_back('{data: 32'd0, lv: 1'b0, mis: 1'b1, cyc: cyc});
  endtask

  task automatic op(input bit ld, st, input logic [2:0] f3, input logic [31:0] a, d,
                    input int stalls, input bit fl, rs);
    for (int i = 0; i < stalls; i++) step(1'b1, ld, st, f3, a, d, 1'b1, 1'b0, 1'b0);
    step(1'b1, ld, st, f3, a, d, 1'b0, fl, rs);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    held = '{data: 32'd0, lv: 1'b0, mis: 1'b0, cyc: 0};
    step(1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle();

    op(0, 1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0);
    op(1, 0, 3'd2, 32'h0000_0010, 32'd0, 0, 0, 0);
    op(0, 1, 3'd0, 32'h0000_0013, 32'h0000_00A5, 0, 0, 0);
    op(1, 0, 3'd0, 32'h0000_0013, 32'd0, 0, 0, 0);
    op(1, 0, 3'd4, 32'h0000_0013, 32'd0, 0, 0, 0);
    op(0, 1, 3'd2, 32'h0000_0020, 32'h8001_1234, 0, 0, 0);
    op(1, 0, 3'd1, 32'h0000_0022, 32'd0, 0, 0, 0);
    op(1, 0, 3'd5, 32'h0000_0022, 32'd0, 0, 0, 0);
    op(1, 0, 3'd1, 32'h0000_0020, 32'd0, 0, 0, 0);
    op(1, 0, 3'd2, 32'h0000_0016, 32'd0, 0, 0, 0);
    idle();
    op(0, 1, 3'd1, 32'h0000_0005, 32'h0000_BEEF, 0, 0, 0);
    idle();
    op(0, 1, 3'd2, 32'h8000_0004, 32'h0000_0055, 0, 0, 0);
    op(1, 0, 3'd2, 32'h8000_0004, 32'd0, 0, 0, 0);
    op(1, 0, 3'd2, 32'h0000_0010, 32'd0, 0, 0, 0);
    op(1, 0, 3'd1, 32'h0000_0022, 32'd0, 3, 0, 0);
    op(0, 1, 3'd2, 32'h0000_0010, 32'h1234_5678, 0, 1, 0);
    op(1, 0, 3'd2, 32'h0000_0010, 32'd0, 0, 0, 0);
    op(1, 0, 3'd3, 32'h0000_0010, 32'd0, 0, 0, 0);
    op(0, 1, 3'd4, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0, 0);
    op(1, 0, 3'd2, 32'h0000_0010, 32'd0, 0, 0, 0);
    op(1, 0, 3'd2, 32'h0000_0020, 32'd0, 0, 0, 1);
    idle();
    chk("load_valid_after_reset", {31'd0, load_valid}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      int kind;
      bit ld, st, io;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      ld = (kind >= 2 && kind <= 5);
      st = (kind >= 6);
      io = ($urandom_range(0, 3) == 0);
      a  = io ? 32'h8000_0000 + $urandom_range(0, 255) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) f3 = (kind == 2) ? 3'd4 : (kind == 3) ? 3'd5 : 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 2));
      if (io && st) f3 = 3'd2;
      if (kind < 2) idle();
      else op(ld, st, f3, a, $urandom(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              ($urandom_range(0, 9) == 0), 1'b0);
    end

    idle();
    idle();
    idle();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_lsu.md
Name: ex_mem_lsu

Overview:
Load/store unit sitting directly downstream of the EX-stage ALU. It consumes the ALU result as the effective address and drives the synchronous data memory and IO bus in the EX cycle. It holds an EX/MEM register and, one cycle later, aligns and sign/zero-extends the returned read word for writeback. It also detects misaligned accesses and handles pipeline stall and flush.

Parameters:
DMEM_AW, 12, word-address width driven to data memory (dmem_addr = addr[DMEM_AW+1:2])
IO_NIBBLE, 4'h8, value of addr[31:28] that selects the IO region; any other value selects DMEM

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
valid  in  1  EX-stage instruction valid
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store (is_load and is_store are never both 1)
funct3  in  3  RISC-V width/sign field: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW
addr  in  32  effective address (ALU output)
store_data  in  32  rs2 value after forwarding
stall  in  1  hold the EX/MEM register and suppress memory enables
flush  in  1  kill the EX instruction
dmem_en  out  1  data memory enable
dmem_we  out  4  byte write enables
dmem_addr  out  DMEM_AW  word address
dmem_din  out  32  replicated store data
dmem_dout  in  32  read word, valid the cycle after dmem_en
io_en  out  1  IO access strobe
io_we  out  1  IO write
io_addr  out  32  full address
io_wdata  out  32  raw store_data
io_rdata  in  32  IO read word, valid the cycle after io_en
load_data  out  32  aligned, extended load result (MEM cycle)
load_valid  out  1  load_data is meaningful this cycle
misaligned  out  1  one-cycle pulse in the MEM cycle for a misaligned access

Behaviour:
- EX cycle (combinational):
  - go = valid & (is_load|is_store) & ~stall & ~flush & aligned & legal_funct3.
  - Aligned when: byte accesses always; halfword requires addr[0]=0; word requires addr[1:0]=0.
  - legal_funct3: loads {0,1,2,4,5}; stores {0,1,2}.
  - Region: io_sel = (addr[31:28]==IO_NIBBLE).
  - dmem_en = go & ~io_sel; io_en = go & io_sel.
- Store byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<addr[1:0].
  - SW: 4'b1111.
  - dmem_we is the value above when dmem_en & is_store, else 4'b0000.
  - io_we = io_en & is_store.
- dmem_din: SB = {4{store_data[7:0]}}; SH = {2{store_data[15:0]}}; SW = store_data.
- dmem_addr and io_addr are driven from addr at all times; they are don't-care when enables are 0.
- EX/MEM register, updated on posedge clk:
  - Priority: rst, then flush, then stall, then load.
  - rst or flush: r_valid<=0, r_load<=0, r_mis<=0.
  - stall: all fields hold.
  - Otherwise: r_valid<=valid, r_load<=is_load & go, r_funct3<=funct3, r_off<=addr[1:0], r_io<=io_sel, r_mis<=valid & (is_load|is_store) & ~aligned & legal_funct3.
- MEM cycle:
  - word = r_io ? io_rdata : dmem_dout.
  - Byte extract: word>>(8*r_off). Halfword extract: word>>(8*{r_off[1],1'b0}).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - load_data is forced to 0 when r_load=0.
  - load_valid = r_valid & r_load.
  - misaligned = r_valid & r_mis.
- Stall: enables are gated off, so the synchronous memory output holds the previous read word. The register also holds, so load_data and load_valid stay stable across any stall length.
- Flush in the same cycle as a store: no write is committed, and the next cycle has load_valid=0 and misaligned=0.
- Illegal funct3: no memory access, no load_valid, no misaligned.
- Reset values: load_valid=0, misaligned=0, load_data=0. All enables are 0 while rst=1 because valid is ignored during reset.
- Latency: store commits in the EX cycle (1 edge); load data is available exactly 1 cycle after the EX cycle, excluding stall cycles.

Test Plan:
- SW addr=0x0000_0010 data=0xDEADBEEF -> dmem_en=1, we=4'hF, dmem_addr=4, din=0xDEADBEEF; a following LW of the same address gives load_data=0xDEADBEEF, load_valid=1 one cycle later.
- SB addr=0x13 data=0x0000_00A5 -> we=4'b1000, din=0xA5A5A5A5; LB 0x13 with dout=0xA5xxxxxx -> 0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr=0x22, dout=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; LH addr=0x20 -> 0x00001234.
- LW addr=0x16 -> no enables, misaligned=1 for exactly one cycle, load_valid=0; SH addr=0x05 gives the same outcome with we=0.
- LW addr=0x8000_0004 -> io_en=1, dmem_en=0; io_rdata=0x55 next cycle gives load_data=0x55. SW to the same address gives io_we=1, io_wdata=store_data.
- LW issued, then stall=1 for 3 cycles -> dmem_en=0 throughout and load_data/load_valid constant. Separately, SW with flush=1 -> we=0 and load_valid=0 next cycle. Reset asserted mid-load -> load_valid=0 on the next edge.
